frame_sequencer: RTL and testbench

Per-frame scheduler for the raycasting datapath. It sequences one frame of ray work by issuing column indices 0..SCREEN_WIDTH-1 to the ray-calculation stage over a valid/ready handshake. It then waits for the transformation stage to report the last column written and requests a frame-buffer swap aligned to the end of the video frame. It sits between `video_sig_gen` and the ray_calculations / dda / transformation / frame_buffer chain, replacing free-running column counters.

---
 rtl/frame_sequencer.sv | 104 ++++++++++
 tb/tb_frame_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame ray column scheduler with end-of-frame buffer swap
// Optional FRAME_SEQ_STATS_EN adds overrun_count_out, a saturating count of skipped frames.
module frame_sequencer #(
    parameter int SCREEN_WIDTH = 320,
    parameter int HW           = $clog2(SCREEN_WIDTH)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic          new_frame_in,
    input  logic          video_last_pixel_in,
    input  logic          enable_in,
    output logic [HW-1:0] ray_hcount_out,
    output logic          ray_valid_out,
    input  logic          ray_ready_in,
    output logic          ray_last_out,
    input  logic          column_done_in,
    output logic          swap_out,
    output logic          busy_out
`ifdef FRAME_SEQ_STATS_EN
   ,output logic [7:0]    overrun_count_out
`endif
);

    localparam logic [HW-1:0] LAST_COL = HW'(SCREEN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        SWAP_WAIT
    } state_t;

    state_t        state, state_n;
    logic [HW-1:0] hcount_n;
    logic          done_flag, done_n;
    logic          swap_n;

    always_comb begin
        state_n  = state;
        hcount_n = ray_hcount_out;
        done_n   = done_flag;
        swap_n   = 1'b0;
        case (state)
            IDLE: begin
                if (new_frame_in && enable_in) begin
                    state_n  = ISSUE;
                    hcount_n = '0;
                    done_n   = 1'b0;
                end
            end
            ISSUE: begin
                // An early completion pulse is latched so DRAIN cannot miss it.
                if (column_done_in) done_n = 1'b1;
                if (ray_valid_out && ray_ready_in) begin
                    if (ray_hcount_out == LAST_COL) state_n = DRAIN;
                    else hcount_n = ray_hcount_out + 1'b1;
                end
            end
            DRAIN: begin
                if (column_done_in) done_n = 1'b1;
                if (done_flag) state_n = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (video_last_pixel_in) begin
                    state_n = IDLE;
                    swap_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they change with the state itself.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            ray_hcount_out <= '0;
            done_flag      <= 1'b0;
            swap_out       <= 1'b0;
            ray_valid_out  <= 1'b0;
            ray_last_out   <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            state          <= state_n;
            ray_hcount_out <= hcount_n;
            done_flag      <= done_n;
            swap_out       <= swap_n;
            ray_valid_out  <= (state_n == ISSUE);
            ray_last_out   <= (state_n == ISSUE) && (hcount_n == LAST_COL);
            busy_out       <= (state_n != IDLE);
        end
    end

`ifdef FRAME_SEQ_STATS_EN
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            overrun_count_out <= '0;
        end else if (new_frame_in && (state != IDLE) && (overrun_count_out != 8'hFF)) begin
            overrun_count_out <= overrun_count_out + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer
module tb_frame_sequencer;

    localparam int W  = 320;
    localparam int HW = 9;

    logic          pixel_clk_in        = 1'b0;
    logic          rst_in              = 1'b1;
    logic          new_frame_in        = 1'b0;
    logic          video_last_pixel_in = 1'b0;
    logic          enable_in           = 1'b0;
    logic          ray_ready_in        = 1'b0;
    logic          column_done_in      = 1'b0;
    logic [HW-1:0] ray_hcount_out;
    logic          ray_valid_out;
    logic          ray_last_out;
    logic          swap_out;
    logic          busy_out;
`ifdef FRAME_SEQ_STATS_EN
    logic [7:0]    overrun_count_out;
`endif

    frame_sequencer #(.SCREEN_WIDTH(W), .HW(HW)) dut (
`ifdef FRAME_SEQ_STATS_EN
        .overrun_count_out  (overrun_count_out),
`endif
        .pixel_clk_in       (pixel_clk_in),
        .rst_in             (rst_in),
        .new_frame_in       (new_frame_in),
        .video_last_pixel_in(video_last_pixel_in),
        .enable_in          (enable_in),
        .ray_hcount_out     (ray_hcount_out),
        .ray_valid_out      (ray_valid_out),
        .ray_ready_in       (ray_ready_in),
        .ray_last_out       (ray_last_out),
        .column_done_in     (column_done_in),
        .swap_out           (swap_out),
        .busy_out           (busy_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    int checks = 0;
    int errors = 0;
    int col_q[$];
    int swap_q[$];
    int swaps_seen = 0;
    int held_hcount = 0;
    bit prev_stall = 1'b0;
    bit prev_swap = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected columns/swaps whenever the DUT presents them.
    always @(negedge pixel_clk_in) begin
        if (rst_in && ray_valid_out && prev_stall)
            check("hold_hcount", int'(ray_hcount_out), held_hcount);
        if (rst_in && ray_valid_out && ray_ready_in) begin
            if (col_q.size() == 0) begin
                check("col_unexpected", int'(ray_hcount_out), -1);
            end else begin
                int exp_col;
                exp_col = col_q.pop_front();
                check("col_hcount", int'(ray_hcount_out), exp_col);
                check("col_last", int'(ray_last_out), (exp_col == W - 1) ? 1 : 0);
            end
        end
        prev_stall  = rst_in && ray_valid_out && !ray_ready_in;
        held_hcount = int'(ray_hcount_out);
        if (swap_out) begin
            swaps_seen++;
            check("swap_expected", (swap_q.size() > 0) ? 1 : 0, 1);
            if (swap_q.size() > 0) void'(swap_q.pop_front());
            check("swap_width", int'(prev_swap), 0);
        end
        prev_swap = swap_out;
    end

    task automatic tick();
        @(posedge pixel_clk_in);
        #1;
    endtask

    task automatic pulse_nf();
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
    endtask

    task automatic pulse_vlp();
        video_last_pixel_in = 1'b1;
        tick();
        video_last_pixel_in = 1'b0;
    endtask

    task automatic pulse_done();
        column_done_in = 1'b1;
        tick();
        column_done_in = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < W; i++) col_q.push_back(i);
    endtask

    task automatic run_issue(input bit toggle, input int done_at);
        bit sent;
        int n;
        sent = 1'b0;
        n    = 0;
        while (ray_valid_out && n < 4 * W) begin
            ray_ready_in   = toggle ? ~ray_ready_in : 1'b1;
            column_done_in = !sent && done_at >= 0 && int'(ray_hcount_out) == done_at;
            if (column_done_in) sent = 1'b1;
            tick();
            n++;
        end
        column_done_in = 1'b0;
        ray_ready_in   = 1'b1;
        check("issue_end_valid", int'(ray_valid_out), 0);
        check("issue_all_cols", col_q.size(), 0);
    endtask

    task automatic finish_swap(input string name);
        pulse_done();
        repeat (3) tick();
        swap_q.push_back(1);
        pulse_vlp();
        check({name, "_swap"}, int'(swap_out), 1);
        check({name, "_busy_low"}, int'(busy_out), 0);
        tick();
        check({name, "_swap_low"}, int'(swap_out), 0);
    endtask

    initial begin
        #3 rst_in = 1'b0;
        tick();
        tick();
        check("rst_valid", int'(ray_valid_out), 0);
        check("rst_hcount", int'(ray_hcount_out), 0);
        check("rst_last", int'(ray_last_out), 0);
        check("rst_swap", int'(swap_out), 0);
        check("rst_busy", int'(busy_out), 0);
`ifdef FRAME_SEQ_STATS_EN
        check("rst_overrun", int'(overrun_count_out), 0);
`endif
        rst_in       = 1'b1;
        enable_in    = 1'b1;
        ray_ready_in = 1'b1;
        tick();

        // Frame 1: full-rate issue, vlp coincident with DRAIN->SWAP_WAIT is ignored.
        push_frame();
        pulse_nf();
        check("start_valid", int'(ray_valid_out), 1);
        check("start_hcount", int'(ray_hcount_out), 0);
        check("start_busy", int'(busy_out), 1);
        run_issue(1'b0, -1);
        repeat (10) tick();
        check("drain_busy", int'(busy_out), 1);
        column_done_in = 1'b1;
        tick();
        column_done_in      = 1'b0;
        video_last_pixel_in = 1'b1;
        tick();
        video_last_pixel_in = 1'b0;
        check("vlp_on_transition_swap", int'(swap_out), 0);
        check("vlp_on_transition_busy", int'(busy_out), 1);
        repeat (3) tick();
        swap_q.push_back(1);
        pulse_vlp();
        check("f1_swap", int'(swap_out), 1);
        check("f1_busy_low", int'(busy_out), 0);
        tick();
        check("f1_swap_low", int'(swap_out), 0);

        // Frame 2: ready toggling every cycle.
        push_frame();
        pulse_nf();
        run_issue(1'b1, -1);
        finish_swap("f2");

        // Frame 3: done pulse early (hcount 200), swap 50 cycles after issue ends.
        push_frame();
        pulse_nf();
        run_issue(1'b0, 200);
        repeat (50) tick();
        check("f3_waiting_busy", int'(busy_out), 1);
        swap_q.push_back(1);
        pulse_vlp();
        check("f3_swap", int'(swap_out), 1);
        check("f3_busy_low", int'(busy_out), 0);
        tick();
        check("f3_swap_low", int'(swap_out), 0);
        check("swap_count_3", swaps_seen, 3);

        // Frame 4: overruns in DRAIN, then new_frame coincident with return to IDLE.
        push_frame();
        pulse_nf();
        run_issue(1'b0, -1);
        pulse_nf();
        tick();
        pulse_nf();
        check("overrun_no_restart", int'(ray_valid_out), 0);
        check("overrun_busy", int'(busy_out), 1);
`ifdef FRAME_SEQ_STATS_EN
        check("overrun_count_2", int'(overrun_count_out), 2);
`endif
        pulse_done();
        repeat (3) tick();
        swap_q.push_back(1);
        new_frame_in        = 1'b1;
        video_last_pixel_in = 1'b1;
        tick();
        new_frame_in        = 1'b0;
        video_last_pixel_in = 1'b0;
        check("f4_swap", int'(swap_out), 1);
        tick();
        check("nf_at_idle_entry_busy", int'(busy_out), 0);
        check("nf_at_idle_entry_valid", int'(ray_valid_out), 0);
`ifdef FRAME_SEQ_STATS_EN
        check("overrun_count_3", int'(overrun_count_out), 3);
`endif

        // Frame 5: stalled in ISSUE while 300 new_frame pulses arrive.
        ray_ready_in = 1'b0;
        push_frame();
        pulse_nf();
        check("f5_valid", int'(ray_valid_out), 1);
        repeat (300) begin
            pulse_nf();
            tick();
        end
        check("f5_stall_hcount", int'(ray_hcount_out), 0);
        check("f5_stall_valid", int'(ray_valid_out), 1);
`ifdef FRAME_SEQ_STATS_EN
        check("overrun_saturate", int'(overrun_count_out), 255);
`endif
        run_issue(1'b0, -1);
        finish_swap("f5");

        // enable_in gating.
        enable_in = 1'b0;
        pulse_nf();
        tick();
        check("disabled_valid", int'(ray_valid_out), 0);
        check("disabled_busy", int'(busy_out), 0);
        enable_in = 1'b1;
        push_frame();
        pulse_nf();
        enable_in = 1'b0;
        run_issue(1'b0, -1);
        finish_swap("f6");
        pulse_nf();
        tick();
        check("disabled_after_busy", int'(busy_out), 0);
        enable_in = 1'b1;

        // Asynchronous reset mid-frame with a pending done flag.
        push_frame();
        pulse_nf();
        for (int n = 0; n < 2 * W && int'(ray_hcount_out) != 100; n++) begin
            column_done_in = (int'(ray_hcount_out) == 50);
            tick();
        end
        column_done_in = 1'b0;
        check("pre_reset_hcount", int'(ray_hcount_out), 100);
        #2 rst_in = 1'b0;
        #1;
        check("async_rst_valid", int'(ray_valid_out), 0);
        check("async_rst_hcount", int'(ray_hcount_out), 0);
        check("async_rst_last", int'(ray_last_out), 0);
        check("async_rst_busy", int'(busy_out), 0);
        check("async_rst_swap", int'(swap_out), 0);
        col_q.delete();
        tick();
        #2 rst_in = 1'b1;
        tick();
        push_frame();
        pulse_nf();
        check("restart_hcount", int'(ray_hcount_out), 0);
        check("restart_valid", int'(ray_valid_out), 1);
        run_issue(1'b0, -1);
        repeat (5) tick();
        pulse_vlp();
        check("stale_done_swap", int'(swap_out), 0);
        check("stale_done_busy", int'(busy_out), 1);
        finish_swap("f7");

        repeat (3) tick();
        check("swap_q_empty", swap_q.size(), 0);
        check("swap_total", swaps_seen, 7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
